// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: PC, synchronous instruction RAM with loader port, and a prefetch FIFO
// feeding decode over valid/ready, with redirect squash, credit flow control and single-step.
module fetch_prefetch_unit #(
  parameter int unsigned        NB_BITS    = 32,
  parameter int unsigned        RAM_DEPTH  = 10,
  parameter int unsigned        FIFO_DEPTH = 4,
  parameter logic [NB_BITS-1:0] RESET_PC   = '0,
  parameter logic [NB_BITS-1:0] NOP        = '0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_run,
  input  logic                           i_step,
  input  logic [NB_BITS-1:0]             i_brq_addr,
  input  logic [NB_BITS-1:0]             i_jmp_addr,
  input  logic                           i_ctr_beq,
  input  logic                           i_ctr_jmp,
  input  logic                           i_id_ready,
  output logic [NB_BITS-1:0]             o_if_id_instr,
  output logic [NB_BITS-1:0]             o_if_id_pc,
  output logic                           o_if_id_valid,
  input  logic [RAM_DEPTH-1:0]           i_wr_addr,
  input  logic [NB_BITS-1:0]             i_wr_data,
  input  logic                           i_wea,
  output logic [NB_BITS-1:0]             o_pc,
  output logic [$clog2(FIFO_DEPTH):0]    o_fifo_count
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;

  logic [NB_BITS-1:0] mem          [2**RAM_DEPTH];
  logic [NB_BITS-1:0] fifo_instr_q [FIFO_DEPTH];
  logic [NB_BITS-1:0] fifo_tag_q   [FIFO_DEPTH];
  logic [NB_BITS-1:0] rdata_q;

  logic [NB_BITS-1:0] pc_q, pc_d, tag_q, tag_d, last_pc_q, last_pc_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               inflight_q, inflight_d, token_q, token_d, step_q, step_d;

  logic               redirect_c, req_c, empty_c, valid_c, take_c, pop_c, push_c;
  logic [NB_BITS-1:0] target_c, pc_plus4_c, head_instr_c, head_tag_c;

  always_comb begin
    redirect_c   = i_ctr_jmp | i_ctr_beq;
    target_c     = i_ctr_jmp ? i_jmp_addr : i_brq_addr;
    pc_plus4_c   = pc_q + NB_BITS'(4);
    // Credit counts the in-flight read so a returning word always has a free slot
    req_c        = (i_run | token_q) & ~redirect_c &
                   ((SW'(count_q) + SW'(inflight_q)) < SW'(FIFO_DEPTH));
    empty_c      = (count_q == '0);
    // An empty FIFO exposes the in-flight RAM word directly for single-cycle latency
    valid_c      = ~empty_c | inflight_q;
    head_instr_c = empty_c ? rdata_q : fifo_instr_q[rd_ptr_q];
    head_tag_c   = empty_c ? tag_q   : fifo_tag_q[rd_ptr_q];
    take_c       = valid_c & i_id_ready & ~redirect_c;
    pop_c        = take_c & ~empty_c;
    push_c       = inflight_q & ~redirect_c & ~(take_c & empty_c);
  end

  // Next-state logic
  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    inflight_d = req_c;
    token_d    = token_q;
    step_d     = i_step;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    last_pc_d  = valid_c ? head_tag_c : last_pc_q;

    if (redirect_c) begin
      pc_d     = target_c & ~NB_BITS'(3);
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (req_c) begin
        pc_d  = pc_plus4_c;
        tag_d = pc_plus4_c;
      end
      if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_c) - CW'(pop_c);
    end

    if (req_c)                  token_d = 1'b0;
    else if (i_step & ~step_q)  token_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
      token_q    <= 1'b0;
      step_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      last_pc_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
      token_q    <= token_d;
      step_q     <= step_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      last_pc_q  <= last_pc_d;
    end
  end

  // Instruction RAM and prefetch storage carry no reset
  always_ff @(posedge i_clk) begin
    if (i_wea & ~i_run) mem[i_wr_addr] <= i_wr_data;
    if (req_c)          rdata_q <= mem[pc_q[RAM_DEPTH+1:2]];
    if (push_c) begin
      fifo_instr_q[wr_ptr_q] <= rdata_q;
      fifo_tag_q[wr_ptr_q]   <= tag_q;
    end
  end

  assign o_if_id_valid = valid_c;
  assign o_if_id_instr = valid_c ? head_instr_c : NOP;
  assign o_if_id_pc    = valid_c ? head_tag_c : last_pc_q;
  assign o_pc          = pc_q;
  assign o_fifo_count  = count_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a queue scoreboard of expected {instr, pc+4}.
module tb_fetch_prefetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } sb_t;

  logic        clk;
  logic        i_rst, i_run, i_step, i_ctr_beq, i_ctr_jmp, i_id_ready, i_wea;
  logic [31:0] i_brq_addr, i_jmp_addr, i_wr_data;
  logic [9:0]  i_wr_addr;
  logic [31:0] o_if_id_instr, o_if_id_pc, o_pc;
  logic        o_if_id_valid;
  logic [2:0]  o_fifo_count;

  sb_t         sb[$];
  logic [31:0] shadow[32];
  int          n_pass = 0;
  int          n_total = 0;

  fetch_prefetch_unit dut (
    .i_clk(clk), .i_rst(i_rst), .i_run(i_run), .i_step(i_step),
    .i_brq_addr(i_brq_addr), .i_jmp_addr(i_jmp_addr),
    .i_ctr_beq(i_ctr_beq), .i_ctr_jmp(i_ctr_jmp), .i_id_ready(i_id_ready),
    .o_if_id_instr(o_if_id_instr), .o_if_id_pc(o_if_id_pc), .o_if_id_valid(o_if_id_valid),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_wea(i_wea),
    .o_pc(o_pc), .o_fifo_count(o_fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard on each accepted output, then advances one clock
  task automatic tick();
    sb_t e;
    if (o_if_id_valid && i_id_ready && !i_ctr_jmp && !i_ctr_beq) begin
      if (sb.size() > 0) e = sb.pop_front();
      else               e = '{instr: 32'hDEADBEEF, pc: 32'hFFFFFFFF};
      chk("sb_instr", o_if_id_instr, e.instr);
      chk("sb_pc", o_if_id_pc, e.pc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget = 30;
    while (sb.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic load(input int a, input logic [31:0] d);
    i_wea = 1'b1; i_wr_addr = 10'(a); i_wr_data = d;
    tick();
    i_wea = 1'b0;
    shadow[a] = d;
  endtask

  task automatic jump(input logic [31:0] a);
    i_ctr_jmp = 1'b1; i_jmp_addr = a;
    tick();
    i_ctr_jmp = 1'b0;
  endtask

  task automatic expect_entry(input int word, input logic [31:0] pc4);
    sb.push_back('{instr: shadow[word], pc: pc4});
  endtask

  initial begin
    i_rst = 1'b1; i_run = 1'b0; i_step = 1'b0; i_ctr_beq = 1'b0; i_ctr_jmp = 1'b0;
    i_id_ready = 1'b0; i_wea = 1'b0; i_brq_addr = '0; i_jmp_addr = '0;
    i_wr_data = '0; i_wr_addr = '0;
    tick(); tick();
    chk("rst_valid", 32'(o_if_id_valid), 32'd0);
    chk("rst_instr", o_if_id_instr, 32'h0);
    chk("rst_ifpc", o_if_id_pc, 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_count", 32'(o_fifo_count), 32'd0);
    i_rst = 1'b0;

    // Loader and free-run throughput
    load(0, 32'h11); load(1, 32'h22); load(2, 32'h33); load(3, 32'h44);
    for (int i = 4; i < 32; i++) load(i, 32'h1000 + 32'(i));
    chk("load_no_fetch", o_pc, 32'h0);
    i_run = 1'b1; i_id_ready = 1'b1;
    for (int i = 0; i < 4; i++) expect_entry(i, 32'(4 * (i + 1)));
    tick();
    chk("lat_valid", 32'(o_if_id_valid), 32'd1);
    chk("lat_instr", o_if_id_instr, 32'h11);
    tick(); tick(); tick();
    i_run = 1'b0;
    drain();
    tick();
    chk("t1_pc", o_pc, 32'd16);
    chk("t1_idle", 32'(o_if_id_valid), 32'd0);
    chk("t1_hold_ifpc", o_if_id_pc, 32'd16);

    // Backpressure: credit saturation then in-order drain
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    i_id_ready = 1'b0; i_run = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("t2_count", 32'(o_fifo_count), 32'd4);
    chk("t2_pc", o_pc, 32'd16);
    i_run = 1'b0; i_id_ready = 1'b1;
    chk("t2_head", o_if_id_instr, 32'h11);
    for (int i = 0; i < 4; i++) expect_entry(i, 32'(4 * (i + 1)));
    drain();
    tick();
    chk("t2_empty", 32'(o_fifo_count), 32'd0);

    // Jump while three entries are buffered
    i_id_ready = 1'b0; i_run = 1'b1;
    tick(); tick(); tick();
    i_run = 1'b0;
    tick();
    chk("t3_count3", 32'(o_fifo_count), 32'd3);
    i_id_ready = 1'b1;
    jump(32'h40);
    chk("t3_drop", 32'(o_if_id_valid), 32'd0);
    chk("t3_flush", 32'(o_fifo_count), 32'd0);
    chk("t3_pc", o_pc, 32'h40);
    i_run = 1'b1;
    expect_entry(16, 32'h44);
    tick();
    i_run = 1'b0;
    chk("t3_tgt_valid", 32'(o_if_id_valid), 32'd1);
    chk("t3_tgt_instr", o_if_id_instr, shadow[16]);
    chk("t3_tgt_ifpc", o_if_id_pc, 32'h44);
    drain();
    i_ctr_beq = 1'b1; i_brq_addr = 32'h80;
    jump(32'h40);
    i_ctr_beq = 1'b0;
    chk("t3_prio", o_pc, 32'h40);
    jump(32'h43);
    chk("t3_align", o_pc, 32'h40);

    // Single-step: a held step fetches once, a fresh pulse fetches again
    i_step = 1'b1;
    expect_entry(16, 32'h44);
    tick(); tick(); tick();
    i_step = 1'b0;
    tick(); tick();
    drain();
    chk("t4_one", o_pc, 32'h44);
    i_step = 1'b1;
    expect_entry(17, 32'h48);
    tick();
    i_step = 1'b0;
    tick(); tick();
    drain();
    chk("t4_two", o_pc, 32'h48);

    // Loader blocked while running; read-during-write returns old data
    i_run = 1'b1; i_wea = 1'b1; i_wr_addr = 10'd0; i_wr_data = 32'hDEAD;
    expect_entry(18, 32'h4C);
    tick();
    i_run = 1'b0; i_wea = 1'b0;
    drain();
    jump(32'h8);
    expect_entry(2, 32'h0C);
    i_step = 1'b1;
    tick();
    i_step = 1'b0; i_wea = 1'b1; i_wr_addr = 10'd2; i_wr_data = 32'h99;
    tick();
    i_wea = 1'b0;
    shadow[2] = 32'h99;
    drain();
    jump(32'h8);
    expect_entry(2, 32'h0C);
    i_step = 1'b1;
    tick();
    i_step = 1'b0;
    tick();
    drain();

    // Mid-operation reset with buffered and in-flight data
    jump(32'h0);
    i_id_ready = 1'b0; i_run = 1'b1;
    tick(); tick(); tick();
    chk("t6_count2", 32'(o_fifo_count), 32'd2);
    i_rst = 1'b1; i_run = 1'b0;
    tick();
    i_rst = 1'b0;
    chk("t6_valid", 32'(o_if_id_valid), 32'd0);
    chk("t6_count", 32'(o_fifo_count), 32'd0);
    chk("t6_pc", o_pc, 32'h0);
    i_run = 1'b1; i_id_ready = 1'b1;
    expect_entry(0, 32'd4); expect_entry(1, 32'd8);
    expect_entry(2, 32'd12); expect_entry(3, 32'd16);
    tick();
    chk("t6_relat", 32'(o_if_id_valid), 32'd1);
    tick(); tick(); tick();
    i_run = 1'b0;
    drain();
    tick();
    chk("t6_end_valid", 32'(o_if_id_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
